// File: rtl/uart_rx_core.sv
// UART receive engine: oversampled start/data/parity/stop deframing with UFIFO push
// and single-cycle completion event pulses.
module uart_rx_core #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_WIDTH = 8,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  rx_en_i,
    input  logic [DIV_WIDTH-1:0]  baud_div_i,
    input  logic                  parity_en_i,
    input  logic                  parity_odd_i,
    input  logic                  stop2_i,
    input  logic                  rxd_i,
    input  logic                  ufifo_full_i,
    output logic                  ufifo_push_o,
    output logic [DATA_WIDTH-1:0] ufifo_wdata_o,
    output logic                  rx_done_o,
    output logic                  parity_err_o,
    output logic                  bad_frame_o,
    output logic                  ufifo_overflow_o,
    output logic                  rx_status_o
);

    localparam int IDX_W = $clog2(OVERSAMPLE);
    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [IDX_W-1:0] IDX_LO   = IDX_W'(OVERSAMPLE / 2 - 1);
    localparam logic [IDX_W-1:0] IDX_MID  = IDX_W'(OVERSAMPLE / 2);
    localparam logic [IDX_W-1:0] IDX_HI   = IDX_W'(OVERSAMPLE / 2 + 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                 state;
    logic                   rxd_meta;
    logic                   rxd_sync;
    logic                   rxd_prev;
    logic [DIV_WIDTH-1:0]   baud_cnt;
    logic [DIV_WIDTH-1:0]   div_q;
    logic                   par_en_q;
    logic                   par_odd_q;
    logic                   stop2_q;
    logic [IDX_W-1:0]       idx;
    logic [CNT_W-1:0]       bit_cnt;
    logic                   stop_cnt;
    logic                   s_lo;
    logic                   s_mid;
    logic [DATA_WIDTH-1:0]  shreg;
    logic                   perr;
    logic                   ferr;
    logic                   tick;
    logic                   start_det;
    logic                   bit_val;

    assign tick      = (state != S_IDLE) && (baud_cnt == div_q);
    assign start_det = (state == S_IDLE) && rx_en_i && rxd_prev && !rxd_sync;
    // Majority vote: two stored mid-bit samples plus the one arriving on the decision tick.
    assign bit_val   = (s_lo & s_mid) | (s_lo & rxd_sync) | (s_mid & rxd_sync);

    // NOTE: synchronizer and edge-history flops reset to the idle (high) line level so a
    // line that is already low after reset is never mistaken for a start edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rxd_meta <= 1'b1;
            rxd_sync <= 1'b1;
            rxd_prev <= 1'b1;
        end else begin
            rxd_meta <= rxd_i;
            rxd_sync <= rxd_meta;
            rxd_prev <= rxd_sync;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            baud_cnt <= '0;
        end else if (start_det || state == S_IDLE || tick) begin
            baud_cnt <= '0;
        end else begin
            baud_cnt <= baud_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state            <= S_IDLE;
            div_q            <= '0;
            par_en_q         <= 1'b0;
            par_odd_q        <= 1'b0;
            stop2_q          <= 1'b0;
            idx              <= '0;
            bit_cnt          <= '0;
            stop_cnt         <= 1'b0;
            s_lo             <= 1'b0;
            s_mid            <= 1'b0;
            shreg            <= '0;
            perr             <= 1'b0;
            ferr             <= 1'b0;
            ufifo_push_o     <= 1'b0;
            ufifo_wdata_o    <= '0;
            rx_done_o        <= 1'b0;
            parity_err_o     <= 1'b0;
            bad_frame_o      <= 1'b0;
            ufifo_overflow_o <= 1'b0;
            rx_status_o      <= 1'b0;
        end else begin
            ufifo_push_o     <= 1'b0;
            rx_done_o        <= 1'b0;
            parity_err_o     <= 1'b0;
            bad_frame_o      <= 1'b0;
            ufifo_overflow_o <= 1'b0;
            if (start_det) begin
                state       <= S_START;
                div_q       <= baud_div_i;
                par_en_q    <= parity_en_i;
                par_odd_q   <= parity_odd_i;
                stop2_q     <= stop2_i;
                idx         <= '0;
                bit_cnt     <= '0;
                stop_cnt    <= 1'b0;
                perr        <= 1'b0;
                ferr        <= 1'b0;
                rx_status_o <= 1'b1;
            end else if (tick) begin
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
                if (idx == IDX_LO)  s_lo  <= rxd_sync;
                if (idx == IDX_MID) s_mid <= rxd_sync;
                case (state)
                    S_START: begin
                        if (idx == IDX_HI && bit_val) begin
                            state       <= S_IDLE;
                            rx_status_o <= 1'b0;
                        end else if (idx == IDX_LAST) begin
                            state <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        if (idx == IDX_HI) shreg <= {bit_val, shreg[DATA_WIDTH-1:1]};
                        if (idx == IDX_LAST) begin
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt == BIT_LAST) state <= par_en_q ? S_PARITY : S_STOP;
                        end
                    end
                    S_PARITY: begin
                        if (idx == IDX_HI) perr <= ((^shreg) ^ par_odd_q) != bit_val;
                        if (idx == IDX_LAST) state <= S_STOP;
                    end
                    S_STOP: begin
                        // Completing at mid-bit of the last stop bit leaves half a bit to
                        // catch a back-to-back start edge.
                        if (idx == IDX_HI) begin
                            if (stop2_q && !stop_cnt) begin
                                ferr <= ferr | ~bit_val;
                            end else begin
                                state       <= S_IDLE;
                                rx_status_o <= 1'b0;
                                if (ferr || !bit_val) begin
                                    bad_frame_o <= 1'b1;
                                end else begin
                                    rx_done_o    <= 1'b1;
                                    parity_err_o <= perr;
                                    if (ufifo_full_i) begin
                                        ufifo_overflow_o <= 1'b1;
                                    end else begin
                                        ufifo_push_o  <= 1'b1;
                                        ufifo_wdata_o <= shreg;
                                    end
                                end
                            end
                        end
                        if (idx == IDX_LAST) stop_cnt <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
- Serial receive engine for the UART IP: the line-side counterpart of the upstream FIFO register path.
- Oversamples `rxd_i` and deframes start/data/parity/stop bits. Pushes each received byte into the upstream FIFO (UFIFO).
- Raises single-cycle event pulses that feed the IRQ_EVENT bits `rx_done`, `uart_parity_err`, `uart_bad_frame` and `ufifo_overflow`, plus the STATS `rx_status` bit.

Parameters:
- OVERSAMPLE, 16, baud ticks per bit; even, ≥8.
- DATA_WIDTH, 8, data bits per frame.
- DIV_WIDTH, 16, width of the baud divider input.

Ports:
- clk_i  in  1  system clock; single clock domain.
- rst_i  in  1  synchronous, active-high reset.
- rx_en_i  in  1  receiver enable.
- baud_div_i  in  DIV_WIDTH  baud tick every baud_div_i+1 clocks.
- parity_en_i  in  1  parity bit present.
- parity_odd_i  in  1  1 = odd parity, 0 = even parity.
- stop2_i  in  1  1 = two stop bits.
- rxd_i  in  1  asynchronous serial input; idle level is high.
- ufifo_full_i  in  1  UFIFO full flag.
- ufifo_push_o  out  1  one-cycle UFIFO write strobe.
- ufifo_wdata_o  out  DATA_WIDTH  received byte; valid when push is high.
- rx_done_o  out  1  pulse: frame received with valid stop bit(s).
- parity_err_o  out  1  pulse: parity mismatch.
- bad_frame_o  out  1  pulse: a stop bit was sampled as 0.
- ufifo_overflow_o  out  1  pulse: byte dropped because UFIFO was full.
- rx_status_o  out  1  1 = frame in progress; 0 = IDLE.

Behaviour:
- Reset:
  - All outputs are 0.
  - The two-flop synchronizer and its edge-history flop reset to 1.
  - FSM goes to IDLE; baud and sample counters clear to 0.
- Reset mid-frame aborts the frame silently: no pulses are generated.
- Baud tick:
  - Counter runs 0..baud_div_i; the tick is asserted in the cycle the counter equals baud_div_i, then the counter wraps to 0.
  - baud_div_i=0 gives a tick every clock.
  - The counter and the sample index are cleared on start detection.
- Start detection: in IDLE with rx_en_i=1, a synchronized falling edge (prev=1, cur=0) moves the FSM to START. Both synchronizer flops must have seen high first.
- Config latch: parity_en_i, parity_odd_i, stop2_i and baud_div_i are latched at start detection. Changes mid-frame have no effect until the next frame.
- Sampling:
  - The sample index runs 0..OVERSAMPLE-1 per bit, advancing on each tick.
  - The bit value is the majority of the samples at indices OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1.
  - The bit decision is made on the tick at index OVERSAMPLE/2+1.
- FSM states:
  - IDLE → START on start detection.
  - START:
    - Start-bit majority = 1 → false start; return to IDLE, no pulses.
    - Otherwise move to DATA at the end of the bit (index OVERSAMPLE-1).
  - DATA: DATA_WIDTH bits, LSB first, shifted into a shift register. Then go to PARITY if parity is enabled, else to STOP.
  - PARITY: the expected bit is the XOR of the data bits, XOR parity_odd. Mismatch sets an internal perr flag.
  - STOP:
    - If stop2=1, the first stop bit runs a full bit period and the decision completes on the second.
    - Any stop sample of 0 sets an internal ferr flag.
    - The frame completes at the mid-bit decision of the last stop bit, not at end of bit, so a back-to-back start edge is caught. FSM returns to IDLE.
- Completion outputs, registered and asserted exactly one clock after the completing tick:
  - ferr=1:
    - bad_frame_o=1.
    - No push, no rx_done_o, no parity_err_o.
  - ferr=0:
    - rx_done_o=1.
    - parity_err_o=perr.
    - If ufifo_full_i=0: ufifo_push_o=1, ufifo_wdata_o=byte.
    - If ufifo_full_i=1: no push, ufifo_overflow_o=1.
    - Bytes with a parity error are still pushed.
- ufifo_wdata_o holds its last value when not pushing.
- rx_status_o is 1 in START, DATA, PARITY and STOP; 0 in IDLE.
- rx_en_i deasserted mid-frame: the current frame completes normally; no new start is accepted.
- Break (line held low): bad_frame_o pulses once. No new start is accepted until the line returns high and falls again.

Test Plan:
- OVERSAMPLE=16, baud_div=0, 8N1, send 0xA5 → ufifo_push_o with wdata=0xA5 and rx_done_o in the same cycle, 9×16+9+1 clocks after the falling edge (+2 for synchronizer). parity_err_o=0, rx_status_o high throughout the frame.
- baud_div=3, even parity, send 0x3C with parity bit 1 → push 0x3C, rx_done_o=1, parity_err_o=1. Repeat with parity bit 0 → parity_err_o=0.
- 8N1, send 0x81 with stop bit 0 → bad_frame_o pulse, no push, no rx_done_o. Then hold line low for 3 frames → no further pulses until a rising then falling edge occurs.
- Low glitch of 4 clocks at baud_div=0 → false start, FSM back in IDLE, zero pulses. A following 0x55 frame is received correctly.
- ufifo_full_i=1, send 0x12 → ufifo_overflow_o=1 and rx_done_o=1, ufifo_push_o=0.
- rst_i pulsed during data bit 3 of 0xFF → all outputs 0 the next cycle, no pulses. The next frame 0x5A is pushed correctly. Two back-to-back frames with stop2=1 → both bytes pushed.
